// File: rtl/ghostbus_host_arbiter_pkg.sv
// Shared types and constants for the ghostbus two-master host arbiter.
// The optional GHOSTBUS_ARB_FIXED_PRIO_EN macro is consumed by ghostbus_rr_pick.
package ghostbus_host_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Wide enough to hold the largest legal read latency.
  localparam int LAT_W  = 4;
  localparam int RL_MIN = 1;
  localparam int RL_MAX = 15;

  function automatic int clamp_rl(input int rl);
    if (rl < RL_MIN) return RL_MIN;
    if (rl > RL_MAX) return RL_MAX;
    return rl;
  endfunction

endpackage

// File: rtl/ghostbus_host_arbiter_if.sv
// Single-beat host request/response port; one instance per bus master.
// master = the requesting bridge, slave = the arbiter side.
interface ghostbus_host_arbiter_if #(
  parameter int AW = 24,
  parameter int DW = 32
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/ghostbus_rr_pick.sv
// Two-way request picker producing a one-hot grant while enabled.
// Define GHOSTBUS_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins ties).
module ghostbus_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] grant
);

`ifdef GHOSTBUS_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end
  end
`else
  // On a tie the master that did not win last time gets the bus.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end
`endif

endmodule

// File: rtl/ghostbus_host_arbiter.sv
// Serialises single-beat requests from two masters onto one ghostbus host port.
// Tie policy is round-robin unless GHOSTBUS_ARB_FIXED_PRIO_EN is defined.
module ghostbus_host_arbiter
  import ghostbus_host_arbiter_pkg::*;
#(
  parameter int AW = 24,
  parameter int DW = 32,
  parameter int RL = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ghostbus_host_arbiter_if.slave  h0,
  ghostbus_host_arbiter_if.slave  h1,
  output logic [AW-1:0]           gb_addr,
  output logic [DW-1:0]           gb_dout,
  output logic                    gb_we,
  output logic                    gb_re,
  input  logic [DW-1:0]           gb_din,
  output logic                    busy,
  output logic [1:0]              gnt
);

  localparam int              RL_C  = clamp_rl(RL);
  localparam logic [LAT_W-1:0] RL_LD = LAT_W'(RL_C);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             we_q, we_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic             gb_we_q, gb_we_d;
  logic             gb_re_q, gb_re_d;
  logic             busy_q, busy_d;
  logic [1:0]       ack_q, ack_d;
  logic [DW-1:0]    rdata0_q, rdata0_d;
  logic [DW-1:0]    rdata1_q, rdata1_d;
  logic [1:0]       pick;

  ghostbus_rr_pick u_pick (
    .req   ({h1.req, h0.req}),
    .last  (last_q),
    .en    (state_q == ST_IDLE),
    .grant (pick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE:  if (pick != 2'b00) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = RL_LD;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q == LAT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    addr_d   = addr_q;
    dout_d   = dout_q;
    we_d     = we_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gb_we_d  = 1'b0;
    gb_re_d  = 1'b0;
    ack_d    = 2'b00;
    busy_d   = (state_d != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (pick != 2'b00) begin
          addr_d  = pick[1] ? h1.addr  : h0.addr;
          dout_d  = pick[1] ? h1.wdata : h0.wdata;
          we_d    = pick[1] ? h1.we    : h0.we;
          gnt_d   = pick;
          last_d  = pick[1];
          gb_we_d = we_d;
          gb_re_d = !we_d;
          // A write completes in its single strobe cycle.
          ack_d   = we_d ? pick : 2'b00;
        end
      end
      ST_ISSUE: if (we_q) gnt_d = 2'b00;
      ST_WAIT: begin
        if (cnt_q == LAT_W'(1)) begin
          ack_d = gnt_q;
          if (gnt_q[0]) rdata0_d = gb_din;
          if (gnt_q[1]) rdata1_d = gb_din;
        end
      end
      ST_DONE:  gnt_d = 2'b00;
      default:  gnt_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      dout_q   <= '0;
      we_q     <= 1'b0;
      last_q   <= 1'b1;
      gnt_q    <= 2'b00;
      gb_we_q  <= 1'b0;
      gb_re_q  <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      we_q     <= we_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      gb_we_q  <= gb_we_d;
      gb_re_q  <= gb_re_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign gb_addr  = addr_q;
  assign gb_dout  = dout_q;
  assign gb_we    = gb_we_q;
  assign gb_re    = gb_re_q;
  assign busy     = busy_q;
  assign gnt      = gnt_q;
  assign h0.ack   = ack_q[0];
  assign h1.ack   = ack_q[1];
  assign h0.rdata = rdata0_q;
  assign h1.rdata = rdata1_q;

endmodule

// File: tb/tb_ghostbus_host_arbiter.sv
// Bench for ghostbus_host_arbiter: dut_a (RL=1) is tracked every cycle by a
// transaction-level model; dut_b (RL=4) gets directed latency and reset checks.
module tb_ghostbus_host_arbiter;

  localparam int AW   = 24;
  localparam int DW   = 32;
  localparam int RL_A = 1;
  localparam int RL_B = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  ghostbus_host_arbiter_if #(.AW(AW), .DW(DW)) h0a ();
  ghostbus_host_arbiter_if #(.AW(AW), .DW(DW)) h1a ();
  ghostbus_host_arbiter_if #(.AW(AW), .DW(DW)) h0b ();
  ghostbus_host_arbiter_if #(.AW(AW), .DW(DW)) h1b ();

  logic [AW-1:0] gb_addr_a, gb_addr_b;
  logic [DW-1:0] gb_dout_a, gb_dout_b, gb_din_a, gb_din_b;
  logic          gb_we_a, gb_we_b, gb_re_a, gb_re_b, busy_a, busy_b;
  logic [1:0]    gnt_a, gnt_b;

  // Read data tags the cycle it is presented in, so a capture on the wrong cycle shows.
  int            ovr_cyc_a = -1, ovr_cyc_b = -1;
  logic [DW-1:0] ovr_val_a = '0, ovr_val_b = '0;
  assign gb_din_a = (cyc == ovr_cyc_a) ? ovr_val_a : {cyc[7:0], gb_addr_a};
  assign gb_din_b = (cyc == ovr_cyc_b) ? ovr_val_b : {cyc[7:0], gb_addr_b};

  ghostbus_host_arbiter #(.AW(AW), .DW(DW), .RL(RL_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .h0(h0a), .h1(h1a),
    .gb_addr(gb_addr_a), .gb_dout(gb_dout_a), .gb_we(gb_we_a), .gb_re(gb_re_a),
    .gb_din(gb_din_a), .busy(busy_a), .gnt(gnt_a)
  );

  ghostbus_host_arbiter #(.AW(AW), .DW(DW), .RL(RL_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .h0(h0b), .h1(h1b),
    .gb_addr(gb_addr_b), .gb_dout(gb_dout_b), .gb_we(gb_we_b), .gb_re(gb_re_b),
    .gb_din(gb_din_b), .busy(busy_b), .gnt(gnt_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model of dut_a ----------------
  // A granted transaction occupies cycles m_start..m_end; the cycle after is idle.
  int            m_start = 0;
  int            m_end   = -1;
  int            m_owner = 0;
  bit            m_we    = 1'b0;
  bit            m_last  = 1'b1;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata [2] = '{default: '0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_end = -1; m_owner = 0; m_we = 1'b0; m_last = 1'b1;
      m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    end else begin
      int c;
      c = cyc;
      if (c > m_end) begin
        bit r0, r1, p1;
        r0 = h0a.req;
        r1 = h1a.req;
        if (r0 || r1) begin
`ifdef GHOSTBUS_ARB_FIXED_PRIO_EN
          p1 = !r0;
`else
          p1 = (r0 && r1) ? !m_last : r1;
`endif
          m_owner = int'(p1);
          m_last  = p1;
          m_we    = p1 ? h1a.we    : h0a.we;
          m_addr  = p1 ? h1a.addr  : h0a.addr;
          m_wdata = p1 ? h1a.wdata : h0a.wdata;
          m_start = c + 1;
          m_end   = m_we ? c + 1 : c + 2 + RL_A;
        end
      end else if (!m_we && c == m_start + RL_A) begin
        m_rdata[m_owner] = (c == ovr_cyc_a) ? ovr_val_a : {c[7:0], m_addr};
      end
    end
  end

  always @(negedge clk) begin
    bit act;
    act = (cyc >= m_start) && (cyc <= m_end);
    check("a.busy",  busy_a,  act);
    check("a.gnt",   gnt_a,   act ? (m_owner == 1 ? 2'b10 : 2'b01) : 2'b00);
    check("a.gb_we", gb_we_a, act && cyc == m_start && m_we);
    check("a.gb_re", gb_re_a, act && cyc == m_start && !m_we);
    check("a.h0_ack", h0a.ack, act && cyc == m_end && m_owner == 0);
    check("a.h1_ack", h1a.ack, act && cyc == m_end && m_owner == 1);
    check("a.gb_addr", gb_addr_a, m_addr);
    check("a.gb_dout", gb_dout_a, m_wdata);
    check("a.h0_rdata", h0a.rdata, m_rdata[0]);
    check("a.h1_rdata", h1a.rdata, m_rdata[1]);
  end

  logic [1:0] glog [$];
  always @(negedge clk) if (gb_we_a || gb_re_a) glog.push_back(gnt_a);

  // ---------------- host drivers (h: 0/1 -> dut_a, 2/3 -> dut_b) ----------------
  task automatic drive(input int h, input bit req, input bit we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    case (h)
      0:       begin h0a.req = req; h0a.we = we; h0a.addr = addr; h0a.wdata = wd; end
      1:       begin h1a.req = req; h1a.we = we; h1a.addr = addr; h1a.wdata = wd; end
      2:       begin h0b.req = req; h0b.we = we; h0b.addr = addr; h0b.wdata = wd; end
      default: begin h1b.req = req; h1b.we = we; h1b.addr = addr; h1b.wdata = wd; end
    endcase
  endtask

  function automatic logic ack_of(input int h);
    case (h)
      0:       return h0a.ack;
      1:       return h1a.ack;
      2:       return h0b.ack;
      default: return h1b.ack;
    endcase
  endfunction

  function automatic logic [1:0] gnt_of(input int h);
    return (h < 2) ? gnt_a : gnt_b;
  endfunction

  function automatic logic strobe_of(input int h);
    return (h < 2) ? (gb_we_a || gb_re_a) : (gb_we_b || gb_re_b);
  endfunction

  function automatic logic [AW-1:0] addr_of(input int h);
    return (h < 2) ? gb_addr_a : gb_addr_b;
  endfunction

  // Raise a request, hold it until ack. lat = cycles from request cycle to ack cycle.
  task automatic run_host(input int h, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int din_at, input logic [DW-1:0] din_val,
                          output int lat, output int strobes, output bit addr_ok);
    logic [1:0] mine;
    mine = (h % 2 == 0) ? 2'b01 : 2'b10;
    @(posedge clk);
    #1;
    if (din_at >= 0) begin
      if (h < 2) begin ovr_cyc_a = cyc + din_at; ovr_val_a = din_val; end
      else       begin ovr_cyc_b = cyc + din_at; ovr_val_b = din_val; end
    end
    drive(h, 1'b1, we, addr, wd);
    lat = -1; strobes = 0; addr_ok = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (gnt_of(h) == mine) begin
        if (strobe_of(h)) strobes++;
        if (addr_of(h) !== addr) addr_ok = 1'b0;
      end
      if (ack_of(h)) begin
        lat = i;
        break;
      end
    end
    check($sformatf("host%0d ack seen", h), lat >= 0, 1'b1);
  endtask

  task automatic idle_host(input int h);
    @(posedge clk);
    #1;
    drive(h, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, stb;
    bit aok;
    rst_n = 1'b0;
    for (int h = 0; h < 4; h++) drive(h, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #2;
    check("rst busy_a", busy_a, 1'b0);
    check("rst gnt_a", gnt_a, 2'b00);
    check("rst gb_addr_a", gb_addr_a, 24'h0);
    check("rst busy_b", busy_b, 1'b0);
    check("rst h0b_ack", h0b.ack, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // h0 write 0x000040 <- 0xDEADBEEF: strobe, data and ack all in T+1.
    run_host(0, 1'b1, 24'h000040, 32'hDEADBEEF, -1, '0, lat, stb, aok);
    check("wr lat", lat, 1);
    check("wr gb_we", gb_we_a, 1'b1);
    check("wr gb_addr", gb_addr_a, 24'h000040);
    check("wr gb_dout", gb_dout_a, 32'hDEADBEEF);
    check("wr strobes", stb, 1);
    idle_host(0);

    // h1 read 0x000042 with gb_din = 0x42 only in T+2: ack at T+3.
    run_host(1, 1'b0, 24'h000042, '0, 2, 32'h00000042, lat, stb, aok);
    check("rd lat", lat, 3);
    check("rd h1_rdata", h1a.rdata, 32'h00000042);
    check("rd h0_ack", h0a.ack, 1'b0);
    check("rd h0_rdata", h0a.rdata, 32'h0);
    check("rd strobes", stb, 1);
    idle_host(1);

    // Both masters contend for four transactions.
    glog.delete();
    fork
      begin
        int l0, s0; bit o0;
        run_host(0, 1'b1, 24'h000100, 32'h11111111, -1, '0, l0, s0, o0);
        run_host(0, 1'b1, 24'h000101, 32'h22222222, -1, '0, l0, s0, o0);
        idle_host(0);
      end
      begin
        int l1, s1; bit o1;
        run_host(1, 1'b1, 24'h000200, 32'h33333333, -1, '0, l1, s1, o1);
        run_host(1, 1'b1, 24'h000201, 32'h44444444, -1, '0, l1, s1, o1);
        idle_host(1);
      end
    join
    check("tie count", glog.size(), 4);
    if (glog.size() == 4) begin
`ifdef GHOSTBUS_ARB_FIXED_PRIO_EN
      check("tie g0", glog[0], 2'b01);
      check("tie g1", glog[1], 2'b01);
      check("tie g2", glog[2], 2'b10);
      check("tie g3", glog[3], 2'b10);
`else
      check("tie g0", glog[0], 2'b01);
      check("tie g1", glog[1], 2'b10);
      check("tie g2", glog[2], 2'b01);
      check("tie g3", glog[3], 2'b10);
`endif
    end

    // Two-master traffic; the model checks every cycle.
    fork
      for (int h = 0; h < 2; h++) begin
        automatic int hh = h;
        fork
          for (int n = 0; n < 30; n++) begin
            int lr, sr, gap; bit orr;
            run_host(hh, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, -1, '0, lr, sr, orr);
            check($sformatf("rnd h%0d strobes", hh), sr, 1);
            check($sformatf("rnd h%0d addr stable", hh), orr, 1'b1);
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
              idle_host(hh);
              repeat (gap - 1) @(posedge clk);
            end
          end
        join_none
      end
    join
    wait fork;
    idle_host(0);
    idle_host(1);

    // dut_b, RL=4: read from h0 with a write from h1 arriving mid-read.
    fork
      begin
        int l0, s0; bit o0;
        run_host(2, 1'b0, 24'h000300, '0, 5, 32'h12345678, l0, s0, o0);
        check("rl4 lat", l0, 6);
        check("rl4 rdata", h0b.rdata, 32'h12345678);
        check("rl4 strobes", s0, 1);
        check("rl4 addr stable", o0, 1'b1);
        idle_host(2);
      end
      begin
        int l1, s1; bit o1;
        repeat (2) @(posedge clk);
        run_host(3, 1'b1, 24'h000301, 32'hCAFEF00D, -1, '0, l1, s1, o1);
        check("rl4 held-off lat", l1, 6);
        check("rl4 held-off dout", gb_dout_b, 32'hCAFEF00D);
        idle_host(3);
      end
    join
    check("rl4 h1_rdata", h1b.rdata, 32'h0);

    // Reset during WAIT on dut_b.
    @(posedge clk);
    #1;
    drive(2, 1'b1, 1'b0, 24'h0003AA, '0);
    repeat (3) @(posedge clk);
    #2;
    check("pre-rst busy_b", busy_b, 1'b1);
    check("pre-rst gnt_b", gnt_b, 2'b01);
    rst_n = 1'b0;
    #1;
    check("rst busy_b", busy_b, 1'b0);
    check("rst gnt_b", gnt_b, 2'b00);
    check("rst gb_re_b", gb_re_b, 1'b0);
    check("rst h0b_ack", h0b.ack, 1'b0);
    check("rst h0b_rdata", h0b.rdata, 32'h0);
    check("rst gb_addr_b", gb_addr_b, 24'h0);
    drive(2, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_host(3, 1'b1, 24'h0003BB, 32'h00000005, -1, '0, lat, stb, aok);
    check("post-rst lat", lat, 1);
    check("post-rst gb_addr", gb_addr_b, 24'h0003BB);
    check("post-rst h0b_ack", h0b.ack, 1'b0);
    idle_host(3);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
